nand_rsff_bank: RTL
===================

NAND_RSFF_BANK -- requirements
Module: nand_rsff_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent latch channels (1..32).
REQ-002 Parameter FILTER, default 0: input glitch-filter length in CLK_DRV cycles (0..15); 0 disables the filter.
REQ-003 Parameter RACE_MODE, default 0: resolution when both-low is released together: 0 = restore last stable Q, 1 = set, 2 = reset.
REQ-004 Parameter INIT_Q, default all-zero, width CHANNELS: Q value per channel after reset.
REQ-005 CLK_DRV  input  1  single drive clock; all state SHALL change only on its rising edge.
REQ-006 RST_N  input  1  synchronous, active-low reset, sampled on the CLK_DRV rising edge.
REQ-007 S_N  input  CHANNELS  active-low set, one bit per channel.
REQ-008 R_N  input  CHANNELS  active-low reset, one bit per channel.
REQ-009 Q  output  CHANNELS  latch output, registered.
REQ-010 Q_N  output  CHANNELS  complementary latch output, registered.
REQ-011 Q_RISE  output  CHANNELS  one-cycle pulse when Q goes 0->1.
REQ-012 Q_FALL  output  CHANNELS  one-cycle pulse when Q goes 1->0.

Function
REQ-013 Channels SHALL be fully independent; no channel's state SHALL depend on another channel's inputs.
REQ-014 Per channel, the accepted pair (s,r) SHALL equal the raw (S_N,R_N) when FILTER=0, sampled each edge.
REQ-015 When FILTER>0, a per-channel counter SHALL count consecutive edges on which the raw pair equals a candidate pair differing from the accepted pair; the candidate is accepted when the count reaches FILTER.
REQ-016 When the raw pair equals the accepted pair, or changes to a new candidate, the counter SHALL restart (0, or 1 for a new candidate); pulses shorter than FILTER cycles SHALL never be accepted.
REQ-017 Latency: raw input change to Q/Q_N change SHALL be 1 cycle when FILTER=0 and FILTER+1 cycles otherwise.
REQ-018 Accepted (0,1): Q=1, Q_N=0. Accepted (1,0): Q=0, Q_N=1. Accepted (1,1): hold.
REQ-019 Accepted (0,0): Q=1 and Q_N=1 (faithful NAND behaviour); the last stable Q from before entering (0,0) SHALL be retained internally.
REQ-020 Per-channel states: STABLE (Q/Q_N complementary) and BOTHLOW; enter BOTHLOW on accepted (0,0), leave on any other accepted pair.
REQ-021 BOTHLOW -> (0,1) or (1,0): apply REQ-018 directly; RACE_MODE not used.
REQ-022 BOTHLOW -> (1,1) (simultaneous release): Q = retained stable Q (RACE_MODE 0), 1 (RACE_MODE 1), 0 (RACE_MODE 2); Q_N = ~Q.
REQ-023 RACE_MODE 3 SHALL behave as RACE_MODE 0.
REQ-024 Q_RISE/Q_FALL SHALL be registered, asserted in the same cycle Q shows the new value, for exactly one cycle; entering BOTHLOW from Q=0 SHALL pulse Q_RISE; leaving BOTHLOW to Q=0 SHALL pulse Q_FALL.
REQ-025 Q_N SHALL always equal ~Q except in BOTHLOW.

Reset
REQ-026 RST_N low at a CLK_DRV rising edge SHALL set Q=INIT_Q, Q_N=~INIT_Q, Q_RISE=0, Q_FALL=0, accepted pair=(1,1), filter counters=0, state=STABLE, retained Q=INIT_Q.
REQ-027 Reset SHALL take priority over all input activity, including mid-filter counts and BOTHLOW.
REQ-028 On the first edge after RST_N goes high, inputs SHALL be processed normally; with S_N=0 held through reset, Q rises at release+1 cycle (FILTER=0).

Verification
REQ-029 FILTER=0, ch0: S_N=0 one cycle, then 1 -> Q[0]=1, Q_N[0]=0 next cycle, Q_RISE[0] one-cycle pulse, hold afterwards; R_N=0 one cycle -> Q[0]=0, Q_FALL[0] pulse.
REQ-030 FILTER=3: S_N=0 for 2 cycles -> Q unchanged; S_N=0 for 3 cycles -> Q=1 exactly 4 cycles after the first low sample.
REQ-031 BOTHLOW with Q=0, RACE_MODE 0: S_N=R_N=0 -> Q=1,Q_N=1, Q_RISE pulse; both released same edge -> Q=0,Q_N=1, Q_FALL pulse; repeat for RACE_MODE 1 (Q=1) and 2 (Q=0).
REQ-032 BOTHLOW -> R_N released first (S_N still 0) -> Q=1,Q_N=0, no Q_FALL/Q_RISE pulse.
REQ-033 CHANNELS=4, INIT_Q=4'b1010: reset -> Q=1010, Q_N=0101; set ch0 and reset ch3 on same edge -> Q=0011, other channels unchanged.
REQ-034 Assert RST_N low mid-filter count (FILTER=3, count=2) -> outputs return to INIT_Q; input pending before reset not accepted early after release.

Source files
------------

// File: rtl/nand_rsff_bank.sv
// Bank of independent NAND-style RS latches with optional input glitch filter and race resolution.
// Latency: raw input change to Q/Q_N is 1 CLK_DRV cycle when FILTER=0, FILTER+1 cycles otherwise.
// Backpressure: none; inputs are sampled every CLK_DRV rising edge and outputs are always valid.
module nand_rsff_bank #(
  parameter int                  CHANNELS  = 4,
  parameter int                  FILTER    = 0,
  parameter int                  RACE_MODE = 0,
  parameter logic [CHANNELS-1:0] INIT_Q    = '0
) (
  input  logic                CLK_DRV,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] S_N,
  input  logic [CHANNELS-1:0] R_N,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] Q_N,
  output logic [CHANNELS-1:0] Q_RISE,
  output logic [CHANNELS-1:0] Q_FALL
);

  // Accepted (s,r) pair seen by the latch core.
  logic [CHANNELS-1:0] eff_s;
  logic [CHANNELS-1:0] eff_r;

  generate
    if (FILTER == 0) begin : g_nofilt
      // Unfiltered: the latch core consumes the raw pair directly on each edge.
      assign eff_s = S_N;
      assign eff_r = R_N;
    end else begin : g_filt
      localparam logic [3:0] FILT = 4'(FILTER);

      logic [CHANNELS-1:0] acc_s;
      logic [CHANNELS-1:0] acc_r;
      logic [CHANNELS-1:0] cand_s;
      logic [CHANNELS-1:0] cand_r;
      logic [3:0]          cnt [CHANNELS];

      // Debounce: a new pair must be seen on FILTER consecutive edges before it is accepted.
      always_ff @(posedge CLK_DRV) begin
        if (!RST_N) begin
          acc_s  <= '1;
          acc_r  <= '1;
          cand_s <= '1;
          cand_r <= '1;
          for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (S_N[i] == acc_s[i] && R_N[i] == acc_r[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] != 4'd0 && S_N[i] == cand_s[i] && R_N[i] == cand_r[i]) begin
              if (cnt[i] + 4'd1 >= FILT) begin
                acc_s[i] <= S_N[i];
                acc_r[i] <= R_N[i];
                cnt[i]   <= '0;
              end else begin
                cnt[i] <= cnt[i] + 4'd1;
              end
            end else begin
              // Fresh candidate: this edge is its first sighting.
              cand_s[i] <= S_N[i];
              cand_r[i] <= R_N[i];
              if (FILT == 4'd1) begin
                acc_s[i] <= S_N[i];
                acc_r[i] <= R_N[i];
                cnt[i]   <= '0;
              end else begin
                cnt[i] <= 4'd1;
              end
            end
          end
        end
      end

      assign eff_s = acc_s;
      assign eff_r = acc_r;
    end
  endgenerate

  // Per-channel FSM state: bit set means BOTHLOW, clear means STABLE.
  logic [CHANNELS-1:0] bothlow;
  logic [CHANNELS-1:0] bothlow_nxt;
  // Last complementary Q before entering BOTHLOW, used when both inputs release together.
  logic [CHANNELS-1:0] held_q;
  logic [CHANNELS-1:0] held_q_nxt;
  logic [CHANNELS-1:0] q_nxt;
  logic [CHANNELS-1:0] qn_nxt;

  // State register for the BOTHLOW flag and retained stable Q.
  always_ff @(posedge CLK_DRV) begin
    if (!RST_N) begin
      bothlow <= '0;
      held_q  <= INIT_Q;
    end else begin
      bothlow <= bothlow_nxt;
      held_q  <= held_q_nxt;
    end
  end

  // Next-state: any accepted (0,0) enters BOTHLOW, anything else returns to STABLE.
  always_comb begin
    bothlow_nxt = '0;
    held_q_nxt  = held_q;
    for (int i = 0; i < CHANNELS; i++) begin
      bothlow_nxt[i] = !eff_s[i] && !eff_r[i];
      // While STABLE, Q itself is the stable value to remember.
      held_q_nxt[i]  = bothlow[i] ? held_q[i] : Q[i];
    end
  end

  // Output decode: NAND truth table plus race resolution on simultaneous release.
  always_comb begin
    q_nxt  = Q;
    qn_nxt = Q_N;
    for (int i = 0; i < CHANNELS; i++) begin
      case ({eff_s[i], eff_r[i]})
        2'b00: begin
          q_nxt[i]  = 1'b1;
          qn_nxt[i] = 1'b1;
        end
        2'b01: begin
          q_nxt[i]  = 1'b1;
          qn_nxt[i] = 1'b0;
        end
        2'b10: begin
          q_nxt[i]  = 1'b0;
          qn_nxt[i] = 1'b1;
        end
        default: begin
          if (bothlow[i]) begin
            if (RACE_MODE == 1)      q_nxt[i] = 1'b1;
            else if (RACE_MODE == 2) q_nxt[i] = 1'b0;
            else                     q_nxt[i] = held_q[i];
          end else begin
            q_nxt[i] = Q[i];
          end
          qn_nxt[i] = ~q_nxt[i];
        end
      endcase
    end
  end

  // Output registers; edge pulses line up with the cycle Q shows its new value.
  always_ff @(posedge CLK_DRV) begin
    if (!RST_N) begin
      Q      <= INIT_Q;
      Q_N    <= ~INIT_Q;
      Q_RISE <= '0;
      Q_FALL <= '0;
    end else begin
      Q      <= q_nxt;
      Q_N    <= qn_nxt;
      Q_RISE <= q_nxt & ~Q;
      Q_FALL <= ~q_nxt & Q;
    end
  end

endmodule
